// File: rtl/icache_pkg.sv
// Shared constants and state encoding for the icache AXI line-refill engine.
package icache_pkg;

  localparam int LINE_WORDS = 8;
  localparam int OFFSET_W   = 5;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [7:0] AXI_LEN_LINE   = 8'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    AR,
    R,
    DONE
  } refill_state_e;

endpackage

// File: rtl/icache_axi_refill.sv
// 8-beat AXI4 INCR read-burst engine that fills one icache line and pulses gnt.
// Optional `define ICACHE_REFILL_ERR_EN adds a bus_err output pulsed with gnt.
module icache_axi_refill
  import icache_pkg::*;
#(
  parameter int                  ID_WIDTH = 4,
  parameter logic [ID_WIDTH-1:0] ARID_VAL = '0
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                rd_req,
  input  logic [31:0]         rd_addr,
  output logic                gnt,
  output logic [31:0]         line_data [0:LINE_WORDS-1],
`ifdef ICACHE_REFILL_ERR_EN
  output logic                bus_err,
`endif
  output logic [ID_WIDTH-1:0] arid,
  output logic [31:0]         araddr,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic                arvalid,
  input  logic                arready,
  input  logic [ID_WIDTH-1:0] rid,
  input  logic [31:0]         rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready
);

  localparam logic [2:0] LAST_BEAT = 3'(LINE_WORDS - 1);

  refill_state_e state_q, state_d;
  logic [31:0]   araddr_q, araddr_d;
  logic          arvalid_q, arvalid_d;
  logic          rready_q, rready_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [31:0]   line_q [LINE_WORDS];
  logic          beat;

  assign beat = rvalid & rready_q;

`ifdef ICACHE_REFILL_ERR_EN
  logic err_q, err_d;
  logic bus_err_q, bus_err_d;
  logic beat_err;
  logic unused_inputs;

  // A beat is bad on a non-OKAY response or an rlast that disagrees with the count.
  assign beat_err      = (rresp != AXI_RESP_OKAY) || (rlast != (cnt_q == LAST_BEAT));
  assign bus_err       = bus_err_q;
  assign unused_inputs = ^rid;
`else
  logic unused_inputs;
  assign unused_inputs = ^{rid, rresp, rlast};
`endif

  always_comb begin
    state_d   = state_q;
    araddr_d  = araddr_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    cnt_d     = cnt_q;
`ifdef ICACHE_REFILL_ERR_EN
    err_d     = err_q;
    bus_err_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (rd_req) begin
          state_d   = AR;
          araddr_d  = {rd_addr[31:OFFSET_W], {OFFSET_W{1'b0}}};
          arvalid_d = 1'b1;
          cnt_d     = '0;
`ifdef ICACHE_REFILL_ERR_EN
          err_d     = 1'b0;
`endif
        end
      end
      AR: begin
        if (arvalid_q && arready) begin
          state_d   = R;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      R: begin
        if (beat) begin
          cnt_d = cnt_q + 3'd1;
`ifdef ICACHE_REFILL_ERR_EN
          err_d = err_q | beat_err;
`endif
          if (cnt_q == LAST_BEAT) begin
            state_d  = DONE;
            rready_d = 1'b0;
`ifdef ICACHE_REFILL_ERR_EN
            bus_err_d = err_q | beat_err;
`endif
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      araddr_q  <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      cnt_q     <= '0;
`ifdef ICACHE_REFILL_ERR_EN
      err_q     <= 1'b0;
      bus_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      araddr_q  <= araddr_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      cnt_q     <= cnt_d;
`ifdef ICACHE_REFILL_ERR_EN
      err_q     <= err_d;
      bus_err_q <= bus_err_d;
`endif
    end
  end

  // Each word only changes when its own beat arrives, so the line stays intact after DONE.
  for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_line
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        line_q[gi] <= '0;
      end else if (beat && (cnt_q == 3'(gi))) begin
        line_q[gi] <= rdata;
      end
    end
    assign line_data[gi] = line_q[gi];
  end

  assign gnt     = (state_q == DONE);
  assign arid    = ARID_VAL;
  assign araddr  = araddr_q;
  assign arlen   = AXI_LEN_LINE;
  assign arsize  = AXI_SIZE_4B;
  assign arburst = AXI_BURST_INCR;
  assign arvalid = arvalid_q;
  assign rready  = rready_q;

endmodule

// File: tb/tb_icache_axi_refill.sv
// Randomized self-checking bench for icache_axi_refill; honours ICACHE_REFILL_ERR_EN.
module tb_icache_axi_refill;

  localparam int         ID_WIDTH = 4;
  localparam logic [3:0] ARID_VAL = 4'h5;

  logic                clk = 1'b0;
  logic                resetn = 1'b1;
  logic                rd_req = 1'b0;
  logic [31:0]         rd_addr = '0;
  logic                gnt;
  logic [31:0]         line_data [0:7];
  logic [ID_WIDTH-1:0] arid;
  logic [31:0]         araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready = 1'b0;
  logic [ID_WIDTH-1:0] rid = '0;
  logic [31:0]         rdata = '0;
  logic [1:0]          rresp = '0;
  logic                rlast = 1'b0;
  logic                rvalid = 1'b0;
  logic                rready;
`ifdef ICACHE_REFILL_ERR_EN
  logic                bus_err;
`endif

  icache_axi_refill #(.ID_WIDTH(ID_WIDTH), .ARID_VAL(ARID_VAL)) dut (
    .clk(clk), .resetn(resetn), .rd_req(rd_req), .rd_addr(rd_addr), .gnt(gnt),
    .line_data(line_data),
`ifdef ICACHE_REFILL_ERR_EN
    .bus_err(bus_err),
`endif
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Expected outputs for the current cycle, maintained by the stimulus timeline.
  logic        exp_arvalid = 1'b0;
  logic        exp_rready = 1'b0;
  logic        exp_gnt = 1'b0;
  logic        exp_bus_err = 1'b0;
  logic [31:0] exp_araddr = '0;
  logic [31:0] exp_line [8];

  // Per-transaction plan: idle cycles before each beat, beat payloads and flags.
  int          plan_gap [8];
  logic [31:0] plan_data [8];
  logic [1:0]  plan_resp [8];
  logic        plan_last [8];

  int   req_cyc = 0;
  int   last_gnt_cyc = 0;
  logic last_gnt_err = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h cyc=%0d", name, act, expv, cyc);
    end
  endfunction

  always @(negedge clk) begin
    chk("arvalid", 32'(arvalid), 32'(exp_arvalid));
    chk("rready", 32'(rready), 32'(exp_rready));
    chk("gnt", 32'(gnt), 32'(exp_gnt));
    chk("araddr", araddr, exp_araddr);
    for (int i = 0; i < 8; i++) chk($sformatf("line_data[%0d]", i), line_data[i], exp_line[i]);
    chk("arid", 32'(arid), 32'(ARID_VAL));
    chk("arlen", 32'(arlen), 32'd7);
    chk("arsize", 32'(arsize), 32'd2);
    chk("arburst", 32'(arburst), 32'd1);
`ifdef ICACHE_REFILL_ERR_EN
    chk("bus_err", 32'(bus_err), 32'(exp_bus_err));
`endif
    if (gnt === 1'b1) begin
      last_gnt_cyc = cyc;
`ifdef ICACHE_REFILL_ERR_EN
      last_gnt_err = bus_err;
`endif
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic plan_default();
    for (int b = 0; b < 8; b++) begin
      plan_gap[b]  = 0;
      plan_data[b] = 32'((b + 1) * 32'h11);
      plan_resp[b] = 2'b00;
      plan_last[b] = (b == 7);
    end
  endtask

  task automatic do_reset();
    #2;
    resetn = 1'b0;
    rd_req = 1'b0;
    exp_arvalid = 1'b0; exp_rready = 1'b0; exp_gnt = 1'b0; exp_bus_err = 1'b0;
    exp_araddr = '0;
    for (int i = 0; i < 8; i++) exp_line[i] = '0;
    #1;
    chk("async_rst_rready", 32'(rready), 32'd0);
    chk("async_rst_araddr", araddr, 32'd0);
    chk("async_rst_line0", line_data[0], 32'd0);
    chk("async_rst_line2", line_data[2], 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  // Called #1 after a rising edge with the DUT idle; returns #1 after an edge, DUT idle.
  task automatic refill(input logic [31:0] addr, input int ar_delay, input bit hold,
                        input int abort_after);
    bit err;
    err = 1'b0;
    rd_req  = 1'b1;
    rd_addr = addr;
    @(posedge clk); #1;
    req_cyc     = cyc;
    exp_arvalid = 1'b1;
    exp_araddr  = {addr[31:5], 5'b0};
    rd_req      = 1'($urandom_range(0, 1));
    rd_addr     = $urandom;
    arready     = (ar_delay == 0);
    for (int d = 0; d < ar_delay; d++) begin
      @(posedge clk); #1;
      rd_req  = 1'($urandom_range(0, 1));
      rd_addr = $urandom;
      arready = (d == ar_delay - 1);
    end
    @(posedge clk); #1;
    arready     = 1'b0;
    exp_arvalid = 1'b0;
    exp_rready  = 1'b1;
    for (int b = 0; b < 8; b++) begin
      for (int g = 0; g < plan_gap[b]; g++) begin
        rvalid = 1'b0;
        rdata  = $urandom;
        rresp  = 2'($urandom);
        rlast  = 1'($urandom);
        rd_req = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      rvalid = 1'b1;
      rdata  = plan_data[b];
      rresp  = plan_resp[b];
      rlast  = plan_last[b];
      if (plan_resp[b] != 2'b00 || plan_last[b] != (b == 7)) err = 1'b1;
      rd_req = (b == 7) ? hold : 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      rvalid = 1'b0;
      rdata  = $urandom;
      rresp  = 2'b00;
      rlast  = 1'b0;
      exp_line[b] = plan_data[b];
      if (b == abort_after) begin
        do_reset();
        return;
      end
    end
    exp_rready  = 1'b0;
    exp_gnt     = 1'b1;
    exp_bus_err = err;
    @(posedge clk); #1;
    exp_gnt     = 1'b0;
    exp_bus_err = 1'b0;
    if (!hold) rd_req = 1'b0;
  endtask

  initial begin
    bit hold;
    for (int i = 0; i < 8; i++) exp_line[i] = '0;
    #2 resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    idle(1);

    // Zero-wait refill with hand-computed results.
    plan_default();
    last_gnt_cyc = 0;
    refill(32'hBFC0_0014, 0, 1'b0, -1);
    chk("lat_zero_wait", 32'(last_gnt_cyc - req_cyc + 1), 32'd10);
    chk("lit_araddr", araddr, 32'hBFC0_0000);
    chk("lit_line0", line_data[0], 32'h0000_0011);
    chk("lit_line3", line_data[3], 32'h0000_0044);
    chk("lit_line7", line_data[7], 32'h0000_0088);
    idle(2);

    // arready held off for 3 cycles.
    plan_default();
    last_gnt_cyc = 0;
    refill(32'h0000_1234, 3, 1'b0, -1);
    chk("lat_ar_stall", 32'(last_gnt_cyc - req_cyc + 1), 32'd13);
    chk("lit_araddr2", araddr, 32'h0000_1220);
    idle(1);

    // rvalid low for 2 cycles before beats 2 and 5.
    plan_default();
    for (int b = 0; b < 8; b++) plan_data[b] = 32'hA0A0_0000 + 32'(b);
    plan_gap[2] = 2;
    plan_gap[5] = 2;
    last_gnt_cyc = 0;
    refill(32'h8000_0040, 0, 1'b0, -1);
    chk("lat_r_gaps", 32'(last_gnt_cyc - req_cyc + 1), 32'd14);
    chk("lit_gap_line5", line_data[5], 32'hA0A0_0005);
    idle(1);

    // rd_req held through DONE: back-to-back refills.
    plan_default();
    refill(32'h1000_0000, 0, 1'b1, -1);
    for (int b = 0; b < 8; b++) plan_data[b] = 32'h5555_0000 + 32'(b);
    refill(32'h2000_0020, 1, 1'b0, -1);
    idle(1);

    // Reset mid-burst, then a normal refill.
    plan_default();
    refill(32'h3000_0000, 0, 1'b0, 3);
    idle(1);
    plan_default();
    last_gnt_cyc = 0;
    refill(32'h3000_0080, 0, 1'b0, -1);
    chk("lat_after_rst", 32'(last_gnt_cyc - req_cyc + 1), 32'd10);
    idle(1);

`ifdef ICACHE_REFILL_ERR_EN
    plan_default();
    plan_resp[3] = 2'b10;
    refill(32'h4000_0000, 0, 1'b0, -1);
    chk("err_resp_beat3", 32'(last_gnt_err), 32'd1);
    idle(1);
    plan_default();
    refill(32'h4000_0020, 0, 1'b0, -1);
    chk("err_clean", 32'(last_gnt_err), 32'd0);
    idle(1);
    plan_default();
    plan_last[6] = 1'b1;
    refill(32'h4000_0040, 0, 1'b0, -1);
    chk("err_rlast_beat6", 32'(last_gnt_err), 32'd1);
    idle(1);
`endif

    // Randomized refills.
    for (int t = 0; t < 24; t++) begin
      plan_default();
      for (int b = 0; b < 8; b++) begin
        plan_gap[b]  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
        plan_data[b] = $urandom;
`ifdef ICACHE_REFILL_ERR_EN
        if ($urandom_range(0, 15) == 0) plan_resp[b] = 2'($urandom_range(1, 3));
        if ($urandom_range(0, 15) == 0) plan_last[b] = ~plan_last[b];
`else
        plan_resp[b] = 2'($urandom);
        plan_last[b] = 1'($urandom);
`endif
      end
      hold = ($urandom_range(0, 3) == 0);
      refill($urandom, int'($urandom_range(0, 3)), hold, -1);
      if (!hold) idle(int'($urandom_range(0, 3)));
    end
    rd_req = 1'b0;
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
